// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [7:0]  IMEM_TIMEOUT_DEF = 8'd16;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_sel.sv
// Redirect source select: trap wins over branch; the chosen target is
// word-aligned and a misalignment flag is raised when low bits were set.
module fetch_redirect_sel
  import fetch_pkg::*;
(
  input  logic        i_trap_req,
  input  logic [31:0] i_trap_vector,
  input  logic        i_branch_req,
  input  logic [31:0] i_branch_target,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  logic [31:0] w_raw_target;

  assign w_raw_target = i_trap_req ? i_trap_vector : i_branch_target;
  assign o_redirect   = i_trap_req | i_branch_req;
  assign o_target     = align_word(w_raw_target);
  assign o_misaligned = o_redirect & (w_raw_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: drives the PC register through enable/select/target
// and moves one instruction at a time from instruction memory to decode.
//
// state   | meaning
// BOOT    | first cycle after reset, load RESET_VECTOR into the PC
// REQ     | request instruction at iPC, wait for grant
// WAIT    | request accepted, wait for returned instruction (timeout guarded)
// HOLD    | instruction captured during stall, waiting for decode to accept
// HALTED  | fetching stopped; only a trap restarts it
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [7:0]  IMEM_TIMEOUT = IMEM_TIMEOUT_DEF
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic [31:0] iPC,
  input  logic        iTrapReq,
  input  logic [31:0] iTrapVector,
  input  logic        iBranchReq,
  input  logic [31:0] iBranchTarget,
  input  logic        iStall,
  input  logic        iHalt,
  output logic        oIMemReq,
  output logic [31:0] oIMemAddr,
  input  logic        iIMemGnt,
  input  logic        iIMemValid,
  input  logic [31:0] iIMemData,
  output logic        oPCEn,
  output logic        oPCSrc,
  output logic [31:0] oTargetPC,
  output logic [31:0] oInstr,
  output logic        oInstrValid,
  output logic        oFlush,
  output logic        oHalted,
  output logic        oFetchErr,
  output logic        oMisaligned
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_buf, w_buf_nxt;
  logic         r_kill, w_kill_nxt;
  logic [7:0]   r_cnt, w_cnt_nxt;
  logic         r_fetch_err, w_err_nxt;

  logic         w_trap_ok, w_branch_ok;
  logic         w_redirect, w_redir_mis;
  logic [31:0]  w_redir_target;

  // Branches are meaningless while halted; nothing redirects the boot load.
  assign w_trap_ok   = iTrapReq & (r_state != ST_BOOT);
  assign w_branch_ok = iBranchReq & (r_state != ST_BOOT) & (r_state != ST_HALTED);

  fetch_redirect_sel u_redirect_sel (
    .i_trap_req      (w_trap_ok),
    .i_trap_vector   (iTrapVector),
    .i_branch_req    (w_branch_ok),
    .i_branch_target (iBranchTarget),
    .o_redirect      (w_redirect),
    .o_target        (w_redir_target),
    .o_misaligned    (w_redir_mis)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_kill_nxt  = r_kill;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_fetch_err;
    oIMemReq    = 1'b0;
    oPCEn       = 1'b0;
    oPCSrc      = 1'b0;
    oTargetPC   = '0;
    oInstr      = '0;
    oInstrValid = 1'b0;
    oFlush      = 1'b0;
    oHalted     = 1'b0;
    oMisaligned = 1'b0;

    if (w_redirect) begin
      oPCEn       = 1'b1;
      oPCSrc      = 1'b1;
      oTargetPC   = w_redir_target;
      oFlush      = 1'b1;
      oMisaligned = w_redir_mis;
    end

    case (r_state)
      ST_BOOT: begin
        // Gated so that every output reads 0 while reset is held.
        oPCEn       = iRstN;
        oPCSrc      = iRstN;
        oTargetPC   = iRstN ? RESET_VECTOR : '0;
        w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (!w_redirect) begin
          oIMemReq = !iStall;
          if (!iStall && iIMemGnt) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = '0;
            w_kill_nxt  = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt + 8'd1;
        if (iIMemValid) begin
          if (w_redirect || r_kill) begin
            w_state_nxt = ST_REQ;
            w_kill_nxt  = 1'b0;
          end else if (iStall) begin
            w_buf_nxt   = iIMemData;
            w_state_nxt = ST_HOLD;
          end else begin
            oInstr      = iIMemData;
            oInstrValid = 1'b1;
            oPCEn       = 1'b1;
            w_state_nxt = iHalt ? ST_HALTED : ST_REQ;
          end
        end else if (w_redirect) begin
          w_kill_nxt = 1'b1;
        end else if (r_cnt >= IMEM_TIMEOUT - 8'd1) begin
          w_err_nxt   = 1'b1;
          w_kill_nxt  = 1'b0;
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HOLD: begin
        oInstr = r_buf;
        if (w_redirect) begin
          w_buf_nxt   = '0;
          w_state_nxt = ST_REQ;
        end else if (!iStall) begin
          oInstrValid = 1'b1;
          oPCEn       = 1'b1;
          w_state_nxt = iHalt ? ST_HALTED : ST_REQ;
        end
      end
      ST_HALTED: begin
        oHalted = 1'b1;
        if (w_redirect) w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state     <= ST_BOOT;
      r_buf       <= '0;
      r_kill      <= 1'b0;
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_buf       <= w_buf_nxt;
      r_kill      <= w_kill_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fetch_err <= w_err_nxt;
    end
  end

  assign oIMemAddr = oIMemReq ? iPC : '0;
  assign oFetchErr = r_fetch_err;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: PC register and 1-cycle instruction memory models,
// with a scoreboard of expected instructions pushed at grant, popped on delivery.
module tb_fetch_controller;
  import fetch_pkg::*;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic [31:0] iPC;
  logic        iTrapReq;
  logic [31:0] iTrapVector;
  logic        iBranchReq;
  logic [31:0] iBranchTarget;
  logic        iStall;
  logic        iHalt;
  logic        oIMemReq;
  logic [31:0] oIMemAddr;
  logic        iIMemGnt;
  logic        iIMemValid;
  logic [31:0] iIMemData;
  logic        oPCEn;
  logic        oPCSrc;
  logic [31:0] oTargetPC;
  logic [31:0] oInstr;
  logic        oInstrValid;
  logic        oFlush;
  logic        oHalted;
  logic        oFetchErr;
  logic        oMisaligned;

  fetch_controller #(
    .RESET_VECTOR (32'h0000_0100),
    .IMEM_TIMEOUT (8'd16)
  ) u_dut (
    .iClk          (iClk),
    .iRstN         (iRstN),
    .iPC           (iPC),
    .iTrapReq      (iTrapReq),
    .iTrapVector   (iTrapVector),
    .iBranchReq    (iBranchReq),
    .iBranchTarget (iBranchTarget),
    .iStall        (iStall),
    .iHalt         (iHalt),
    .oIMemReq      (oIMemReq),
    .oIMemAddr     (oIMemAddr),
    .iIMemGnt      (iIMemGnt),
    .iIMemValid    (iIMemValid),
    .iIMemData     (iIMemData),
    .oPCEn         (oPCEn),
    .oPCSrc        (oPCSrc),
    .oTargetPC     (oTargetPC),
    .oInstr        (oInstr),
    .oInstrValid   (oInstrValid),
    .oFlush        (oFlush),
    .oHalted       (oHalted),
    .oFetchErr     (oFetchErr),
    .oMisaligned   (oMisaligned)
  );

  always #5 iClk = ~iClk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pc_m;
  int          resp_delay;
  int          next_delay;
  logic [31:0] resp_addr;
  logic        use_ovr;
  logic [31:0] ovr_data;
  logic [31:0] sb_q[$];

  logic        l_req, l_acc, l_pcen, l_psrc, l_flush, l_iv, l_halted, l_err, l_mis;
  logic [31:0] l_addr, l_tgt, l_instr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    return use_ovr ? ovr_data : (NOP_INSTR ^ {addr[24:0], 7'b0});
  endfunction

  // One clock cycle: present memory response, snapshot outputs mid-cycle,
  // score deliveries, then update the PC register and memory models at the edge.
  task automatic step();
    logic [31:0] exp_i;
    iIMemValid = (resp_delay == 0);
    iIMemData  = iIMemValid ? mem_data(resp_addr) : 32'h0;
    iPC        = pc_m;
    #2;
    l_req    = oIMemReq;
    l_acc    = oIMemReq & iIMemGnt;
    l_addr   = oIMemAddr;
    l_pcen   = oPCEn;
    l_psrc   = oPCSrc;
    l_tgt    = oTargetPC;
    l_flush  = oFlush;
    l_iv     = oInstrValid;
    l_instr  = oInstr;
    l_halted = oHalted;
    l_err    = oFetchErr;
    l_mis    = oMisaligned;
    if (iTrapReq || iBranchReq) sb_q.delete();
    if (l_iv) begin
      if (sb_q.size() == 0) check("instr_unexpected", 32'(l_iv), 32'd0);
      else begin
        exp_i = sb_q.pop_front();
        check("instr_data", l_instr, exp_i);
      end
    end
    if (l_acc) begin
      check("imem_addr_eq_pc", l_addr, pc_m);
      sb_q.push_back(mem_data(pc_m));
    end
    @(posedge iClk);
    if (l_pcen) pc_m = l_psrc ? l_tgt : pc_m + 32'd4;
    if (resp_delay == 0) resp_delay = -1;
    else if (resp_delay > 0) resp_delay--;
    if (l_acc) begin
      resp_delay = next_delay;
      resp_addr  = l_addr;
    end
    #1;
  endtask

  initial begin
    iRstN = 1'b0; iTrapReq = 1'b0; iTrapVector = '0; iBranchReq = 1'b0; iBranchTarget = '0;
    iStall = 1'b0; iHalt = 1'b0; iIMemGnt = 1'b1; iIMemValid = 1'b0; iIMemData = '0; iPC = '0;
    pc_m = '0; resp_delay = -1; next_delay = 0; resp_addr = '0; use_ovr = 1'b0; ovr_data = '0;

    // reset state and boot load
    step();
    check("rst_pcen", l_pcen, 0);
    check("rst_req", l_req, 0);
    check("rst_iv", l_iv, 0);
    check("rst_halted", l_halted, 0);
    check("rst_err", l_err, 0);
    check("rst_flush", l_flush, 0);
    check("rst_tgt", l_tgt, 0);
    iRstN = 1'b1;
    step();
    check("boot_pcen", l_pcen, 1);
    check("boot_psrc", l_psrc, 1);
    check("boot_tgt", l_tgt, 32'h100);
    check("boot_flush", l_flush, 0);

    // sequential fetch: one instruction per two cycles
    for (int i = 0; i < 6; i++) begin
      step();
      if (i % 2 == 0) begin
        check("seq_acc", l_acc, 1);
        check("seq_addr", l_addr, 32'h100 + 32'(4 * (i / 2)));
        check("seq_iv_in_req", l_iv, 0);
      end else begin
        check("seq_iv", l_iv, 1);
        check("seq_pcsrc", l_psrc, 0);
        check("seq_req_in_wait", l_req, 0);
      end
    end

    // stall while data returns: captured, delivered on 4th cycle
    use_ovr = 1'b1; ovr_data = 32'hDEAD_BEEF;
    step();
    check("stall_acc_addr", l_addr, 32'h10C);
    iStall = 1'b1;
    step();
    check("stall_w_iv", l_iv, 0);
    check("stall_w_pcen", l_pcen, 0);
    step();
    check("hold1_instr", l_instr, 32'hDEAD_BEEF);
    check("hold1_iv", l_iv, 0);
    check("hold1_req", l_req, 0);
    step();
    check("hold2_iv", l_iv, 0);
    check("hold2_pcen", l_pcen, 0);
    iStall = 1'b0;
    step();
    check("hold_rel_iv", l_iv, 1);
    check("hold_rel_pcen", l_pcen, 1);
    check("hold_rel_psrc", l_psrc, 0);
    use_ovr = 1'b0;
    next_delay = 2;
    step();
    check("post_stall_acc", l_acc, 1);
    check("post_stall_addr", l_addr, 32'h110);
    next_delay = 0;

    // trap and branch together in WAIT: trap wins, late data dropped
    iTrapReq = 1'b1; iTrapVector = 32'h80; iBranchReq = 1'b1; iBranchTarget = 32'h200;
    step();
    check("pri_tgt", l_tgt, 32'h80);
    check("pri_flush", l_flush, 1);
    check("pri_pcen", l_pcen, 1);
    check("pri_psrc", l_psrc, 1);
    check("pri_iv", l_iv, 0);
    iTrapReq = 1'b0; iBranchReq = 1'b0;
    step();
    check("kill_wait_req", l_req, 0);
    check("kill_wait_pcen", l_pcen, 0);
    step();
    check("kill_drop_iv", l_iv, 0);
    check("kill_drop_pcen", l_pcen, 0);
    step();
    check("trap_resume_addr", l_addr, 32'h80);
    step();
    check("trap_resume_iv", l_iv, 1);

    // misaligned branch target
    iBranchReq = 1'b1; iBranchTarget = 32'h203;
    step();
    check("mis_flag", l_mis, 1);
    check("mis_tgt", l_tgt, 32'h200);
    check("mis_flush", l_flush, 1);
    check("mis_req_dropped", l_req, 0);
    iBranchReq = 1'b0;
    step();
    check("mis_pulse_end", l_mis, 0);
    check("mis_resume_addr", l_addr, 32'h200);
    step();
    check("mis_resume_iv", l_iv, 1);

    // halt after delivery; branch ignored while halted; trap restarts
    step();
    check("halt_acc_addr", l_addr, 32'h204);
    iHalt = 1'b1;
    step();
    check("halt_iv", l_iv, 1);
    iHalt = 1'b0;
    iBranchReq = 1'b1; iBranchTarget = 32'h500;
    step();
    check("halted_flag", l_halted, 1);
    check("halted_req", l_req, 0);
    check("halted_branch_pcen", l_pcen, 0);
    iBranchReq = 1'b0;
    iTrapReq = 1'b1; iTrapVector = 32'h300;
    step();
    check("htrap_pcen", l_pcen, 1);
    check("htrap_tgt", l_tgt, 32'h300);
    iTrapReq = 1'b0;
    next_delay = 100;
    step();
    check("htrap_resume_addr", l_addr, 32'h300);
    check("htrap_resume_halted", l_halted, 0);
    next_delay = 0;

    // memory timeout after 16 WAIT cycles
    for (int i = 1; i <= 16; i++) begin
      step();
      check("to_wait_req", l_req, 0);
      if (i == 16) begin
        check("to_w16_halted", l_halted, 0);
        check("to_w16_err", l_err, 0);
      end
    end
    resp_delay = -1;
    step();
    check("to_err", l_err, 1);
    check("to_halted", l_halted, 1);
    check("to_req", l_req, 0);
    iTrapReq = 1'b1; iTrapVector = 32'h40;
    step();
    check("to_trap_tgt", l_tgt, 32'h40);
    check("to_trap_pcen", l_pcen, 1);
    iTrapReq = 1'b0;
    step();
    check("to_resume_addr", l_addr, 32'h40);
    check("to_resume_halted", l_halted, 0);
    check("to_err_sticky", l_err, 1);
    step();
    check("to_resume_iv", l_iv, 1);

    // reset during WAIT, response arrives after release
    next_delay = 5;
    step();
    check("rw_acc_addr", l_addr, 32'h44);
    next_delay = 0;
    step();
    check("rw_wait_iv", l_iv, 0);
    iRstN = 1'b0;
    #1;
    check("rw_rst_pcen", 32'(oPCEn), 0);
    check("rw_rst_req", 32'(oIMemReq), 0);
    check("rw_rst_err", 32'(oFetchErr), 0);
    check("rw_rst_tgt", oTargetPC, 0);
    step();
    iRstN = 1'b1;
    sb_q.delete();
    resp_delay = 1;
    resp_addr  = 32'h44;
    step();
    check("rw_boot_tgt", l_tgt, 32'h100);
    check("rw_boot_pcen", l_pcen, 1);
    check("rw_boot_iv", l_iv, 0);
    step();
    check("rw_late_iv", l_iv, 0);
    check("rw_req_addr", l_addr, 32'h100);
    step();
    check("rw_deliver_iv", l_iv, 1);

    check("sb_drain", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter IMEM_TIMEOUT, 8'd16, max cycles waiting for iIMemValid before oFetchErr.
REQ-003 iClk  in  1  single clock, rising edge.
REQ-004 iRstN  in  1  reset, asynchronous, active-low.
REQ-005 iPC  in  32  current PC from PC register.
REQ-006 iTrapReq / iTrapVector  in  1 / 32  trap redirect, highest priority.
REQ-007 iBranchReq / iBranchTarget  in  1 / 32  execute-stage taken branch/jump.
REQ-008 iStall  in  1  decode hazard stall, do not deliver or advance.
REQ-009 iHalt  in  1  stop fetching after current delivery.
REQ-010 oIMemReq / oIMemAddr  out  1 / 32  instruction memory request, address = iPC.
REQ-011 iIMemGnt  in  1  request accepted this cycle.
REQ-012 iIMemValid / iIMemData  in  1 / 32  returned instruction.
REQ-013 oPCEn / oPCSrc / oTargetPC  out  1 / 1 / 32  PC register update enable, mux select, target.
REQ-014 oInstr / oInstrValid  out  32 / 1  instruction to decode.
REQ-015 oFlush  out  1  one-cycle pulse, kill younger pipeline stages.
REQ-016 oHalted / oFetchErr / oMisaligned  out  1 each  status.

Function
REQ-017 FSM states BOOT, REQ, WAIT, HOLD, HALTED; BOOT entered only from reset.
REQ-018 BOOT: one cycle, oPCEn=1, oPCSrc=1, oTargetPC=RESET_VECTOR -> REQ.
REQ-019 REQ: oIMemReq=1 unless iStall; iIMemGnt -> WAIT; oIMemAddr=iPC.
REQ-020 WAIT: iIMemValid & !iStall -> oInstrValid=1, oInstr=iIMemData, oPCEn=1, oPCSrc=0 (PC+4), -> REQ; same cycle with iHalt -> HALTED.
REQ-021 WAIT: iIMemValid & iStall -> capture iIMemData in buffer, -> HOLD; PC not advanced.
REQ-022 HOLD: oInstr from buffer; on !iStall assert oInstrValid, oPCEn=1, oPCSrc=0, -> REQ.
REQ-023 Redirect priority trap > branch > sequential; redirect in any state except BOOT: oPCEn=1, oPCSrc=1, oTargetPC=selected target, oFlush=1 same cycle.
REQ-024 Redirect in REQ before grant: request dropped, stay REQ with new PC next cycle.
REQ-025 Redirect in WAIT: set pending-kill flag; returned instruction discarded (oInstrValid=0), then -> REQ; no second PC update.
REQ-026 Redirect in HOLD: buffer discarded, -> REQ.
REQ-027 Redirect overrides iStall; oInstrValid=0 on any redirect cycle.
REQ-028 Target bits[1:0] != 0: oMisaligned pulse 1 cycle, oTargetPC bits[1:0] forced 0.
REQ-029 WAIT timeout counter (8-bit) counts cycles in WAIT; reaching IMEM_TIMEOUT -> oFetchErr sticky 1, -> HALTED; counter cleared on entry to WAIT.
REQ-030 HALTED: oIMemReq=0, oPCEn=0, oHalted=1; exit only by iTrapReq (redirect, -> REQ, oHalted=0) or reset.
REQ-031 Maximum one outstanding memory request; oIMemReq never asserted in WAIT/HOLD.
REQ-032 Sequential throughput: one instruction per two cycles with 1-cycle memory latency.

Reset
REQ-033 iRstN low: immediately FSM=BOOT, all outputs 0, buffer 0, pending-kill 0, counter 0, oFetchErr 0.
REQ-034 Reset mid-WAIT: late iIMemValid after release ignored (not in WAIT).
REQ-035 Release synchronised to iClk by integration; block assumes deassertion meets timing.

Structure
REQ-036 Shared package fetch_pkg: FSM state enum, RESET_VECTOR default, NOP encoding 32'h0000_0013.
REQ-037 Sub-module fetch_redirect_sel: combinational priority select trap/branch with alignment fix; FSM, buffer, counter in top.
REQ-038 Drives existing PCRegister path via oPCEn/oPCSrc/oTargetPC only; no PC storage here.

Verification
REQ-039 Reset release, RESET_VECTOR=32'h100, gnt+valid 1-cycle -> oTargetPC=32'h100 in BOOT, then oInstrValid every 2nd cycle, oIMemAddr 100,104,108.
REQ-040 iStall high when iIMemValid, data 32'hDEADBEEF, stall 3 cycles -> HOLD, oInstr=DEADBEEF valid only on 4th cycle, PC advances once.
REQ-041 iBranchReq target 32'h200 and iTrapReq vector 32'h80 same cycle in WAIT -> oTargetPC=32'h80, oFlush=1, next returned instruction dropped.
REQ-042 iBranchTarget=32'h203 -> oMisaligned pulse, oTargetPC=32'h200.
REQ-043 iIMemValid withheld 16 cycles -> oFetchErr=1, oHalted=1, oIMemReq=0; iTrapReq vector 32'h40 -> fetch resumes at 32'h40.
REQ-044 iRstN low during WAIT, valid arrives one cycle after release -> no oInstrValid, BOOT redirect repeated.
